// File: rtl/lcd_seq_ctrl.sv
// Purpose: sequences a burst of lcd_cnt+1 LCD writes (init table or refresh mux), stepping the index down to 0.
// Latency: strobe one cycle after lcd_enable is sampled; one write per 2 cycles with GAP_CYC=0 and an immediate wr_finish.
// Backpressure: each write waits in WAIT for wr_finish; a TIMEOUT expiry sets lcd_error and ends the burst; lcd_abort ends it at once.
module lcd_seq_ctrl #(
    parameter int CNT_W   = 2,
    parameter int GAP_CYC = 0,
    parameter int TIMEOUT = 255
) (
    input  logic             clk_1ms,
    input  logic             reset,
    input  logic             lcd_enable,
    input  logic             mode,
    input  logic [CNT_W-1:0] lcd_cnt,
    input  logic             lcd_abort,
    input  logic             wr_finish,
    output logic             wr_enable,
    output logic [CNT_W-1:0] init_sel,
    output logic [CNT_W-1:0] mux_sel,
    output logic             lcd_finish,
    output logic             lcd_error,
    output logic             busy
);

    // Counter widths never collapse to zero when a feature is disabled.
    localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [GW-1:0] G_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic             mode_r, mode_nxt;
    logic [CNT_W-1:0] init_nxt, mux_nxt;
    logic [GW-1:0]    gcnt, gcnt_nxt;
    logic [TW-1:0]    tcnt, tcnt_nxt;
    logic             err_nxt, fin_nxt;
    logic [CNT_W-1:0] active_idx;

    // The index being walked by the current burst.
    assign active_idx = mode_r ? init_sel : mux_sel;

    // Next-state and next-output decode; abort overrides the normal flow last.
    always_comb begin
        state_nxt = state;
        mode_nxt  = mode_r;
        init_nxt  = init_sel;
        mux_nxt   = mux_sel;
        gcnt_nxt  = gcnt;
        tcnt_nxt  = tcnt;
        err_nxt   = lcd_error;
        fin_nxt   = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (lcd_enable) begin
                    mode_nxt = mode;
                    err_nxt  = 1'b0;
                    if (mode) init_nxt = lcd_cnt;
                    else      mux_nxt  = lcd_cnt;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tcnt_nxt  = '0;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (wr_finish) begin
                    if (active_idx == '0) begin
                        fin_nxt   = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        if (mode_r) init_nxt = init_sel - 1'b1;
                        else        mux_nxt  = mux_sel - 1'b1;
                        if (GAP_CYC > 0) begin
                            gcnt_nxt  = '0;
                            state_nxt = S_GAP;
                        end else begin
                            state_nxt = S_ISSUE;
                        end
                    end
                end else if ((TIMEOUT > 0) && (tcnt == T_LAST)) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    tcnt_nxt = tcnt + 1'b1;
                end
            end
            S_GAP: begin
                if (gcnt == G_LAST) state_nxt = S_ISSUE;
                else                gcnt_nxt  = gcnt + 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase

        if (lcd_abort && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
            init_nxt  = '0;
            mux_nxt   = '0;
            fin_nxt   = 1'b0;
            err_nxt   = lcd_error;
        end
    end

    // State, counters and all outputs registered; outputs reflect the state being entered.
    always_ff @(posedge clk_1ms) begin
        if (reset) begin
            state      <= S_IDLE;
            mode_r     <= 1'b0;
            init_sel   <= '0;
            mux_sel    <= '0;
            gcnt       <= '0;
            tcnt       <= '0;
            wr_enable  <= 1'b0;
            lcd_finish <= 1'b0;
            lcd_error  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            mode_r     <= mode_nxt;
            init_sel   <= init_nxt;
            mux_sel    <= mux_nxt;
            gcnt       <= gcnt_nxt;
            tcnt       <= tcnt_nxt;
            wr_enable  <= (state_nxt == S_ISSUE);
            lcd_finish <= fin_nxt;
            lcd_error  <= err_nxt;
            busy       <= (state_nxt != S_IDLE);
        end
    end

endmodule
